// File: rtl/text_overlay_pkg.sv
// Shared constants and FSM encoding for the text overlay generator.
package text_overlay_pkg;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam int GLYPH_W = 8;
   localparam int GLYPH_H = 16;

   typedef enum logic {ST_IDLE, ST_CLEAR} ovl_state_e;
endpackage

// File: rtl/font_rom_8x16.sv
// 128-glyph 8x16 font ROM, address {code[6:0], row[3:0]}, registered output.
// Only the glyphs the overlay currently shows are populated; all others are blank.
module font_rom_8x16 (
   input  logic        clk,
   input  logic [10:0] addr_i,
   output logic [7:0]  row_o
);
   logic [7:0] row_d, row_q;
   logic [6:0] code;
   logic [3:0] row;

   assign code = addr_i[10:4];
   assign row  = addr_i[3:0];

   always_comb begin
      row_d = 8'h00;
      unique case (code)
         7'h48: begin // 'H'
            case (row)
               4'd7, 4'd8: row_d = 8'hFE;
               4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
               4'd9, 4'd10, 4'd11, 4'd12, 4'd13: row_d = 8'hC6;
               default: row_d = 8'h00;
            endcase
         end
         7'h45: begin // 'E'
            case (row)
               4'd2, 4'd13: row_d = 8'hFE;
               4'd7, 4'd8:  row_d = 8'hFC;
               4'd3, 4'd4, 4'd5, 4'd6,
               4'd9, 4'd10, 4'd11, 4'd12: row_d = 8'hC0;
               default: row_d = 8'h00;
            endcase
         end
         7'h4C: begin // 'L'
            case (row)
               4'd13: row_d = 8'hFE;
               4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
               4'd8, 4'd9, 4'd10, 4'd11, 4'd12: row_d = 8'hC0;
               default: row_d = 8'h00;
            endcase
         end
         default: row_d = 8'h00;
      endcase
   end

   always_ff @(posedge clk) row_q <= row_d;

   assign row_o = row_q;
endmodule

// File: rtl/text_overlay_gen.sv
// COLS x ROWS text overlay: writable cell RAM, clear sequencer, blink and a
// 3-stage pixel pipeline (area/cell calc -> cell RAM read -> font ROM row).
module text_overlay_gen
   import text_overlay_pkg::*;
#(
   parameter int COLS         = 16,
   parameter int ROWS         = 4,
   parameter int X0           = 64,
   parameter int Y0           = 64,
   parameter int SCALE_SH     = 1,
   parameter int RGB_W        = 12,
   parameter logic [RGB_W-1:0] FG = RGB_W'(12'hFFF),
   parameter logic [RGB_W-1:0] BG = RGB_W'(12'h000),
   parameter int BLINK_FRAMES = 30,
   localparam int AW          = $clog2(COLS*ROWS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             video_on,
   input  logic [9:0]       pix_x,
   input  logic [9:0]       pix_y,
   input  logic             frame_tick,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [AW-1:0]    wr_addr,
   input  logic [7:0]       wr_data,
   input  logic             clr_req,
   output logic             busy,
   output logic             text_on,
   output logic [RGB_W-1:0] rgb_out
);
   localparam int CELLS = COLS * ROWS;
   localparam int CW    = GLYPH_W << SCALE_SH;
   localparam int CH    = GLYPH_H << SCALE_SH;
   localparam int CX_SH = $clog2(GLYPH_W) + SCALE_SH;
   localparam int CY_SH = $clog2(GLYPH_H) + SCALE_SH;
   localparam int BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [10:0] XL = 11'(X0);
   localparam logic [10:0] XH = 11'(X0 + COLS*CW);
   localparam logic [10:0] YL = 11'(Y0);
   localparam logic [10:0] YH = 11'(Y0 + ROWS*CH);

   // ---------------- clear / write sequencer ----------------
   ovl_state_e    state_q, state_d;
   logic [AW-1:0] clr_idx_q, clr_idx_d;
   logic          ram_we;
   logic [AW-1:0] ram_waddr;
   logic [7:0]    ram_wdata;
   logic          addr_ok;

   assign addr_ok = ({1'b0, wr_addr} < (AW+1)'(CELLS));

   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      wr_ready  = 1'b0;
      busy      = 1'b0;
      ram_we    = 1'b0;
      ram_waddr = wr_addr;
      ram_wdata = wr_data;
      case (state_q)
         ST_IDLE: begin
            wr_ready = 1'b1;
            ram_we   = wr_valid & addr_ok;
            if (clr_req) begin
               state_d   = ST_CLEAR;
               clr_idx_d = '0;
            end
         end
         ST_CLEAR: begin
            busy      = 1'b1;
            ram_we    = 1'b1;
            ram_waddr = clr_idx_q;
            ram_wdata = ASCII_SPACE;
            if (clr_idx_q == AW'(CELLS-1)) state_d = ST_IDLE;
            else                           clr_idx_d = clr_idx_q + 1'b1;
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_CLEAR;
         clr_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
      end
   end

   // ---------------- blink ----------------
   logic [BW-1:0] blink_cnt_q;
   logic          blink_phase_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
      end else if (frame_tick) begin
         if (blink_cnt_q == BW'(BLINK_FRAMES-1)) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
         end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
         end
      end
   end

   // ---------------- S1: area and cell decode ----------------
   logic          area_d;
   logic [9:0]    dx, dy;
   logic [AW-1:0] cell_d;

   assign area_d = ({1'b0, pix_x} >= XL) && ({1'b0, pix_x} < XH) &&
                   ({1'b0, pix_y} >= YL) && ({1'b0, pix_y} < YH);
   assign dx     = pix_x - 10'(X0);
   assign dy     = pix_y - 10'(Y0);
   // Out-of-area pixels produce a wrapped, meaningless index; masked by area later.
   assign cell_d = AW'(int'(dy >> CY_SH) * COLS + int'(dx >> CX_SH));

   logic [3:1]    vid_q, area_q;
   logic [AW-1:0] cell_s1_q;
   logic [2:0]    gx_s1_q, gx_s2_q, gx_s3_q;
   logic [3:0]    gy_s1_q, gy_s2_q;
   logic          blink_s3_q;
   logic [7:0]    code_s2_q;
   logic [7:0]    font_row;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vid_q      <= '0;
         area_q     <= '0;
         cell_s1_q  <= '0;
         gx_s1_q    <= '0;
         gx_s2_q    <= '0;
         gx_s3_q    <= '0;
         gy_s1_q    <= '0;
         gy_s2_q    <= '0;
         blink_s3_q <= 1'b0;
      end else begin
         vid_q      <= {vid_q[2:1], video_on};
         area_q     <= {area_q[2:1], area_d};
         cell_s1_q  <= cell_d;
         gx_s1_q    <= 3'(dx >> SCALE_SH);
         gy_s1_q    <= 4'(dy >> SCALE_SH);
         gx_s2_q    <= gx_s1_q;
         gy_s2_q    <= gy_s1_q;
         gx_s3_q    <= gx_s2_q;
         blink_s3_q <= code_s2_q[7];
      end
   end

   // ---------------- S2: cell RAM (power-of-two deep, no reset) ----------------
   logic [7:0] ram_q [2**AW];

   always_ff @(posedge clk) begin
      if (ram_we) ram_q[ram_waddr] <= ram_wdata;
      code_s2_q <= ram_q[cell_s1_q];
   end

   // ---------------- S3: font row ----------------
   font_rom_8x16 u_font (
      .clk    (clk),
      .addr_i ({code_s2_q[6:0], gy_s2_q}),
      .row_o  (font_row)
   );

   logic lit;
   // Leftmost pixel is the MSB: bit index 7-gx, which is ~gx for 3 bits.
   assign lit     = font_row[~gx_s3_q] & ~(blink_s3_q & blink_phase_q);
   assign text_on = vid_q[3] & area_q[3];
   assign rgb_out = !text_on ? '0 : (lit ? FG : BG);
endmodule

// File: tb/tb_text_overlay_gen.sv
// Randomised self-checking bench for text_overlay_gen against a pixel-level model.
module tb_text_overlay_gen;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       video_on = 1'b0;
   logic [9:0] pix_x = '0, pix_y = '0;
   logic       frame_tick = 1'b0;
   logic       wr_valid = 1'b0, wr2_valid = 1'b0;
   logic       wr_ready, wr2_ready;
   logic [5:0] wr_addr = '0, wr2_addr = '0;
   logic [7:0] wr_data = '0, wr2_data = '0;
   logic       clr_req = 1'b0;
   logic       busy, busy2, text_on, text_on2;
   logic [11:0] rgb_out, rgb_out2;

   int checks = 0;
   int errors = 0;

   logic [7:0] cells  [64];
   logic [7:0] cells2 [64];
   int  tick_cnt = 0;
   bit  phase = 1'b0;

   always #5 clk = ~clk;

   text_overlay_gen #(.COLS(16), .ROWS(4), .X0(64), .Y0(64), .SCALE_SH(1), .RGB_W(12),
                      .FG(12'hFFF), .BG(12'h000), .BLINK_FRAMES(30)) dut (
      .clk(clk), .reset(reset), .video_on(video_on), .pix_x(pix_x), .pix_y(pix_y),
      .frame_tick(frame_tick), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
      .wr_data(wr_data), .clr_req(clr_req), .busy(busy), .text_on(text_on), .rgb_out(rgb_out));

   // 48-cell variant so an index past the last cell is representable on wr_addr.
   text_overlay_gen #(.COLS(16), .ROWS(3)) dut2 (
      .clk(clk), .reset(reset), .video_on(video_on), .pix_x(pix_x), .pix_y(pix_y),
      .frame_tick(frame_tick), .wr_valid(wr2_valid), .wr_ready(wr2_ready), .wr_addr(wr2_addr),
      .wr_data(wr2_data), .clr_req(clr_req), .busy(busy2), .text_on(text_on2), .rgb_out(rgb_out2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ffont(input logic [6:0] c, input int r);
      case (c)
         7'h48: return (r < 2 || r > 13) ? 8'h00 : (r == 7 || r == 8) ? 8'hFE : 8'hC6;
         7'h45: return (r == 2 || r == 13) ? 8'hFE : (r == 7 || r == 8) ? 8'hFC :
                       (r > 2 && r < 13) ? 8'hC0 : 8'h00;
         7'h4C: return (r == 13) ? 8'hFE : (r >= 2 && r <= 12) ? 8'hC0 : 8'h00;
         default: return 8'h00;
      endcase
   endfunction

   // Returns {text_on, rgb}: 16x32-pixel cells, each glyph pixel doubled.
   function automatic logic [12:0] mpix(input int x, input int y, input bit v, input bit second);
      int rows = second ? 3 : 4;
      bit in_a = (x >= 64) && (x < 64 + 16*16) && (y >= 64) && (y < 64 + rows*32);
      logic [7:0] c, row;
      int gx;
      bit lit;
      if (!(v && in_a)) return 13'h0;
      c   = second ? cells2[((y-64)/32)*16 + (x-64)/16] : cells[((y-64)/32)*16 + (x-64)/16];
      row = ffont(c[6:0], ((y-64)/2) % 16);
      gx  = ((x-64)/2) % 8;
      lit = row[7-gx] && !(c[7] && phase);
      return {1'b1, lit ? 12'hFFF : 12'h000};
   endfunction

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 64; i++) begin cells[i] = 8'h20; cells2[i] = 8'h20; end
   endtask

   task automatic wr1(input int a, input logic [7:0] d);
      wr_valid = 1'b1; wr_addr = 6'(a); wr_data = d;
      chk("wr_ready", wr_ready, 1);
      cells[a] = d;
      step();
      wr_valid = 1'b0;
   endtask

   task automatic wr2(input int a, input logic [7:0] d);
      wr2_valid = 1'b1; wr2_addr = 6'(a); wr2_data = d;
      chk("wr2_ready", wr2_ready, 1);
      if (a < 48) cells2[a] = d;
      step();
      wr2_valid = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1;
         step();
         frame_tick = 1'b0;
         tick_cnt++;
         if (tick_cnt == 30) begin tick_cnt = 0; phase = !phase; end
      end
   endtask

   // Streams one pixel per clock and checks each result exactly 3 clocks later.
   task automatic sweep(input string tag, input int n, input bit rnd, input int xs, input int ys);
      logic [12:0] q[$];
      logic [12:0] e;
      int x, y;
      bit v;
      for (int i = 0; i < n + 3; i++) begin
         if (i >= 3) begin
            e = q.pop_front();
            chk({tag, ".text_on"}, text_on, e[12]);
            chk({tag, ".rgb"}, rgb_out, e[11:0]);
         end
         if (i < n) begin
            if (rnd) begin
               x = $urandom_range(40, 340); y = $urandom_range(40, 210);
               v = ($urandom_range(0, 7) != 0);
            end else begin
               x = xs + i; y = ys; v = 1'b1;
            end
            pix_x = 10'(x); pix_y = 10'(y); video_on = v;
            q.push_back(mpix(x, y, v, 1'b0));
         end else begin
            video_on = 1'b0;
         end
         step();
      end
   endtask

   task automatic pt(input string tag, input int x, input int y, input bit v);
      logic [12:0] e;
      pix_x = 10'(x); pix_y = 10'(y); video_on = v;
      e = mpix(x, y, v, 1'b0);
      repeat (3) step();
      chk({tag, ".text_on"}, text_on, e[12]);
      chk({tag, ".rgb"}, rgb_out, e[11:0]);
      video_on = 1'b0;
   endtask

   task automatic pt2(input string tag, input int x, input int y);
      logic [12:0] e;
      pix_x = 10'(x); pix_y = 10'(y); video_on = 1'b1;
      e = mpix(x, y, 1'b1, 1'b1);
      repeat (3) step();
      chk({tag, ".text_on"}, text_on2, e[12]);
      chk({tag, ".rgb"}, rgb_out2, e[11:0]);
      video_on = 1'b0;
   endtask

   // Counts clocks until busy drops; a missing drop is caught by the bound.
   task automatic busy_len(input string tag, input int pulse_at);
      int n = 0;
      while (busy && n < 200) begin
         clr_req = (n == pulse_at);
         if (n == 10) chk({tag, ".wr_ready"}, wr_ready, 0);
         step();
         n++;
      end
      clr_req = 1'b0;
      chk({tag, ".busy_cycles"}, n, 64);
   endtask

   logic [7:0] codes [5];

   initial begin
      codes[0] = 8'h20; codes[1] = 8'h48; codes[2] = 8'h45; codes[3] = 8'hC8; codes[4] = 8'h4C;
      model_clear();

      // reset state
      repeat (3) step();
      chk("rst.busy", busy, 1);
      chk("rst.wr_ready", wr_ready, 0);
      chk("rst.text_on", text_on, 0);
      chk("rst.rgb", rgb_out, 0);
      reset = 1'b1;
      busy_len("init", -1);
      sweep("blank", 24, 1'b1, 0, 0);

      // 'H' in cell 0, glyph row 3
      wr1(0, 8'h48);
      sweep("H_row3", 20, 1'b0, 62, 70);

      // blinking 'E' in cell 17
      wr1(17, 8'hC5);
      sweep("E_on", 16, 1'b0, 80, 102);
      ticks(29);
      sweep("E_29", 8, 1'b0, 80, 102);
      ticks(1);
      chk("blink.phase_model", phase, 1);
      sweep("E_off", 16, 1'b0, 80, 102);
      ticks(30);
      sweep("E_back", 16, 1'b0, 80, 102);

      // area boundaries and video gating
      pt("p63_64", 63, 64, 1'b1);
      pt("p320_64", 320, 64, 1'b1);
      pt("p64_192", 64, 192, 1'b1);
      pt("p319_191", 319, 191, 1'b1);
      pt("p64_64_nov", 64, 64, 1'b0);

      // randomised writes, blink ticks and pixel streams
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 3))
            0: wr1($urandom_range(0, 63), codes[$urandom_range(0, 4)]);
            1: sweep("rnd", 12, 1'b1, 0, 0);
            2: ticks($urandom_range(1, 20));
            default: begin
               int c = $urandom_range(0, 63);
               sweep("cell", 16, 1'b0, 64 + (c % 16)*16, 64 + (c / 16)*32 + $urandom_range(0, 31));
            end
         endcase
      end

      // clr_req together with a write: write lands, clear overwrites; second clr_req ignored
      wr_valid = 1'b1; wr_addr = 6'd5; wr_data = 8'h48; clr_req = 1'b1;
      chk("clrwr.wr_ready", wr_ready, 1);
      step();
      wr_valid = 1'b0; clr_req = 1'b0;
      model_clear();
      busy_len("clr", 5);
      sweep("cell5", 16, 1'b0, 144, 70);
      sweep("after_clr", 16, 1'b1, 0, 0);

      // reset in the middle of a clear restarts the full sequence
      wr1(3, 8'h45);
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      repeat (30) step();
      reset = 1'b0;
      #1;
      chk("midrst.busy", busy, 1);
      chk("midrst.wr_ready", wr_ready, 0);
      step();
      reset = 1'b1;
      model_clear();
      phase = 1'b0; tick_cnt = 0;
      busy_len("midrst", -1);
      sweep("cell3", 16, 1'b0, 112, 70);

      // out-of-range write on the 48-cell instance: accepted, nothing changes
      wr2(50, 8'h48);
      pt2("d2_cell2", 100, 70);
      pt2("d2_cell47_blank", 306, 134);
      wr2(47, 8'h48);
      pt2("d2_cell47", 306, 134);
      pt2("d2_cell47b", 310, 134);
      pt2("d2_row3", 100, 170);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
